// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Purpose  : RV32E instruction fetch: owns the PC, fetches one word per
//            instruction over a valid/ready port and holds it for decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  input  logic        exec_done,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;
    fetch_cnt_d  = fetch_cnt_q;
    case (state_q)
      S_RST: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (rsp_err) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            inst_d       = rsp_data;
            inst_valid_d = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + 32'd1;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (exec_done) begin
          inst_valid_d = 1'b0;
          // A misaligned target is reported here, before any fetch is issued
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RST;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      fetch_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign req_valid  = (state_q == S_REQ);
  assign req_addr   = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign fault      = fault_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Self-checking bench for ifu_fetch against an architectural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        exec_done;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fault;
  logic [31:0] fetch_cnt;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .exec_done (exec_done),
    .next_pc   (next_pc),
    .pc        (pc),
    .inst      (inst),
    .inst_valid(inst_valid),
    .fault     (fault),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Architectural model: what the fetch unit should expose at any time.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cnt;
  logic        m_fault;
  logic [31:0] addr_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 32'd0;
    rsp_err   = 1'b0;
    exec_done = 1'b0;
    next_pc   = 32'd0;
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_inst  = 32'd0;
    m_cnt   = 32'd0;
    m_fault = 1'b0;
  endtask

  // Hold reset for n edges, check reset state, then release into REQ.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick();
    model_reset();
    chk("rst_pc", pc, m_pc);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_req_valid", {31'd0, req_valid}, 32'd1);
    chk("rel_req_addr", req_addr, RESET_PC);
  endtask

  // Complete one fetch starting from REQ: stall, accept, wait, respond.
  task automatic fetch_one(input int stall, input int wait_cyc,
                           input logic [31:0] data, input logic err);
    for (int i = 0; i < stall; i++) begin
      req_ready = 1'b0;
      tick();
      chk("stall_req_valid", {31'd0, req_valid}, 32'd1);
      chk("stall_req_addr", req_addr, m_pc);
    end
    chk("acc_req_addr", req_addr, m_pc);
    addr_log.push_back(req_addr);
    req_ready = 1'b1;
    rsp_valid = 1'b1;  // ignored while requesting
    rsp_data  = $urandom;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    chk("wait_req_valid", {31'd0, req_valid}, 32'd0);
    chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < wait_cyc; i++) begin
      exec_done = 1'b1;  // must have no effect outside HOLD
      next_pc   = $urandom;
      tick();
      exec_done = 1'b0;
      chk("wait_pc_stable", pc, m_pc);
      chk("wait_no_valid", {31'd0, inst_valid}, 32'd0);
      chk("wait_no_req", {31'd0, req_valid}, 32'd0);
    end
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    tick();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    if (err) begin
      m_fault = 1'b1;
    end else begin
      m_inst = data;
      m_cnt  = m_cnt + 32'd1;
    end
    chk("rsp_inst", inst, m_inst);
    chk("rsp_inst_valid", {31'd0, inst_valid}, {31'd0, !err});
    chk("rsp_fetch_cnt", fetch_cnt, m_cnt);
    chk("rsp_fault", {31'd0, fault}, {31'd0, m_fault});
  endtask

  // Retire the held instruction after hold_cyc idle HOLD cycles.
  task automatic retire(input int hold_cyc, input logic [31:0] npc);
    for (int i = 0; i < hold_cyc; i++) begin
      tick();
      chk("hold_inst", inst, m_inst);
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_pc", pc, m_pc);
    end
    exec_done = 1'b1;
    next_pc   = npc;
    tick();
    exec_done = 1'b0;
    if (npc[1:0] == 2'b00) m_pc = npc;
    else                   m_fault = 1'b1;
    chk("ret_pc", pc, m_pc);
    chk("ret_inst_kept", inst, m_inst);
    chk("ret_valid", {31'd0, inst_valid}, 32'd0);
    chk("ret_fault", {31'd0, fault}, {31'd0, m_fault});
    chk("ret_req_valid", {31'd0, req_valid}, {31'd0, !m_fault});
    if (!m_fault) chk("ret_req_addr", req_addr, m_pc);
  endtask

  task automatic check_fault_sticky(input int n);
    for (int i = 0; i < n; i++) begin
      req_ready = $urandom_range(0, 1);
      rsp_valid = $urandom_range(0, 1);
      rsp_err   = $urandom_range(0, 1);
      rsp_data  = $urandom;
      exec_done = $urandom_range(0, 1);
      next_pc   = $urandom & 32'hFFFF_FFFC;
      tick();
      chk("flt_fault", {31'd0, fault}, 32'd1);
      chk("flt_valid", {31'd0, inst_valid}, 32'd0);
      chk("flt_req", {31'd0, req_valid}, 32'd0);
      chk("flt_pc", pc, m_pc);
      chk("flt_inst", inst, m_inst);
      chk("flt_cnt", fetch_cnt, m_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    logic [31:0] d;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();

    // Reset and first fetch at minimum latency
    do_reset(3);
    fetch_one(0, 0, 32'h0010_0093, 1'b0);
    chk("first_inst", inst, 32'h0010_0093);
    chk("first_cnt", fetch_cnt, 32'd1);

    // Sequential stream of four instructions
    retire(0, m_pc + 32'd4);
    for (int k = 0; k < 3; k++) begin
      fetch_one($urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0);
      retire($urandom_range(0, 2), m_pc + 32'd4);
    end
    chk("seq_cnt", fetch_cnt, 32'd4);
    chk("seq_addr0", addr_log[0], 32'h8000_0000);
    chk("seq_addr1", addr_log[1], 32'h8000_0004);
    chk("seq_addr2", addr_log[2], 32'h8000_0008);
    chk("seq_addr3", addr_log[3], 32'h8000_000C);

    // Backpressure for 5 cycles with exec_done pulsed during WAIT
    fetch_one(5, 3, $urandom, 1'b0);
    chk("bp_cnt", fetch_cnt, 32'd5);

    // Jump to an aligned target, then random traffic
    retire(1, 32'h8000_0100);
    chk("jmp_addr", req_addr, 32'h8000_0100);
    for (int k = 0; k < 6; k++) begin
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
      retire($urandom_range(0, 3), m_pc + ($urandom_range(0, 63) << 2));
    end

    // Misaligned target
    fetch_one(0, 0, $urandom, 1'b0);
    d = m_pc;
    retire(0, 32'h8000_0102);
    chk("mis_pc", pc, d);
    check_fault_sticky(4);

    // Bus error, then a 1-cycle reset
    do_reset(1);
    fetch_one(1, 1, 32'hDEAD_BEEF, 1'b1);
    check_fault_sticky(5);
    do_reset(1);
    chk("err_restart_pc", pc, RESET_PC);

    // Reset while in WAIT; the late response must be discarded
    fetch_one(0, 0, $urandom, 1'b0);
    retire(0, 32'h8000_0040);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("mw_in_wait", {31'd0, req_valid}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h1234_5678;
    model_reset();
    tick();
    tick();
    rsp_valid = 1'b0;
    chk("mw_inst", inst, 32'd0);
    chk("mw_valid", {31'd0, inst_valid}, 32'd0);
    chk("mw_cnt", fetch_cnt, 32'd0);
    chk("mw_req", {31'd0, req_valid}, 32'd1);
    chk("mw_addr", req_addr, RESET_PC);
    fetch_one(0, 1, $urandom, 1'b0);

    // Counter wrap: preload all-ones while holding, then one more fetch
    @(negedge clk);
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.fetch_cnt_q;
    #1;
    m_cnt = 32'hFFFF_FFFF;
    retire(0, m_pc + 32'd4);
    fetch_one(0, 0, $urandom, 1'b0);
    chk("wrap_cnt", fetch_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
